// File: rtl/peripheral_spram_pkg.sv
// Shared definitions for the Wishbone SPRAM burst peripheral.
// Holds the CTI/BTE encodings, the FSM state type and the burst address stepping function.
package peripheral_spram_pkg;

  localparam int ADR_MAX_W = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } spram_state_t;

  // Wrapping bursts only step the low bits; callers truncate to their own address width.
  function automatic logic [ADR_MAX_W-1:0] wb_next_adr(input logic [ADR_MAX_W-1:0] adr,
                                                       input logic [1:0]           bte);
    logic [ADR_MAX_W-1:0] nxt;
    nxt = adr + ADR_MAX_W'(1);
    case (bte)
      BTE_WRAP4:  nxt = {adr[ADR_MAX_W-1:2], nxt[1:0]};
      BTE_WRAP8:  nxt = {adr[ADR_MAX_W-1:3], nxt[2:0]};
      BTE_WRAP16: nxt = {adr[ADR_MAX_W-1:4], nxt[3:0]};
      default:    ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/peripheral_spram_generic.sv
// DW x DEPTH RAM with per-byte write enables and one registered read port.
// Latency: read data valid the cycle after rd_en. Backpressure: none, accepts a read and a write every cycle.
// Callers keep both addresses below DEPTH.
module peripheral_spram_generic #(
  parameter int    DEPTH   = 256,
  parameter int    DW      = 32,
  parameter int    AW      = 8,
  parameter string MEMFILE = ""
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_adr,
  output logic [DW-1:0]   rd_dat,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_adr,
  input  logic [DW-1:0]   wr_dat,
  input  logic [DW/8-1:0] wr_sel
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  assign rd_idx = IW'(rd_adr);
  assign wr_idx = IW'(wr_adr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wr_sel[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/peripheral_wb_spram_burst.sv
// Wishbone B3 scratch RAM slave with CTI/BTE bursts (built when PERIPHERAL_SPRAM_BURST_EN is defined) and out-of-range error beats.
// Latency: first beat acked 1 cycle after request; held burst beats are acked back-to-back.
// Backpressure: master stalls by dropping stb; the burst address is held until a presented beat is taken.
module peripheral_wb_spram_burst
  import peripheral_spram_pkg::*;
#(
  parameter int    DEPTH   = 256,
  parameter int    DW      = 32,
  parameter int    AW      = $clog2(DEPTH),
  parameter string MEMFILE = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [DW-1:0]   wb_dat_o
);

  localparam logic [ADR_MAX_W:0] DEPTH_X = (ADR_MAX_W+1)'(DEPTH);

  spram_state_t  state;
  spram_state_t  state_nxt;
  logic          req;
  logic          consumed;
  logic          issue;
  logic          issue_err;
  logic [AW-1:0] issue_adr;
  logic [AW-1:0] cur_adr;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] rd_dat;

  assign req = wb_cyc_i & wb_stb_i;
  // A presented beat only completes while the master still holds the request.
  assign consumed = (ack_q | err_q) & req;

`ifdef PERIPHERAL_SPRAM_BURST_EN
  logic [AW-1:0] next_adr;
  logic          last_beat;

  assign next_adr  = AW'(wb_next_adr(ADR_MAX_W'(cur_adr), wb_bte_i));
  assign last_beat = consumed & (wb_cti_i != CTI_INCR);
`else
  logic unused_burst_in;
  assign unused_burst_in = ^{wb_cti_i, wb_bte_i};
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
`ifdef PERIPHERAL_SPRAM_BURST_EN
          state_nxt = (wb_cti_i == CTI_INCR) ? BURST : SINGLE;
`else
          state_nxt = SINGLE;
`endif
        end
      end
      SINGLE: state_nxt = IDLE;
`ifdef PERIPHERAL_SPRAM_BURST_EN
      BURST: begin
        if (!wb_cyc_i || last_beat) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // A beat taken at a stall-free edge prefetches the next address; an untaken one is re-issued.
  always_comb begin
    issue     = 1'b0;
    issue_adr = wb_adr_i;
    case (state)
      IDLE: issue = req;
`ifdef PERIPHERAL_SPRAM_BURST_EN
      BURST: begin
        if (req && !last_beat) begin
          issue     = 1'b1;
          issue_adr = consumed ? next_adr : cur_adr;
        end
      end
`endif
      default: ;
    endcase
  end

  assign issue_err = (ADR_MAX_W+1)'(issue_adr) >= DEPTH_X;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cur_adr <= '0;
    end else begin
      ack_q <= issue & ~issue_err;
      err_q <= issue & issue_err;
      if (issue) cur_adr <= issue_adr;
    end
  end

  peripheral_spram_generic #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .AW      (AW),
    .MEMFILE (MEMFILE)
  ) u_ram (
    .clk    (wb_clk_i),
    .rd_en  (issue & ~issue_err),
    .rd_adr (issue_adr),
    .rd_dat (rd_dat),
    .wr_en  (consumed & ack_q & wb_we_i),
    .wr_adr (cur_adr),
    .wr_dat (wb_dat_i),
    .wr_sel (wb_sel_i)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = ack_q ? rd_dat : '0;

endmodule

// File: tb/tb_peripheral_wb_spram_burst.sv
// Randomised Wishbone master with a word-array reference model and a scoreboard monitor.
module tb_peripheral_wb_spram_burst;

  localparam int DEPTH = 200;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int SW    = DW/8;

  localparam logic [2:0] C_CLASSIC = 3'b000;
  localparam logic [2:0] C_INCR    = 3'b010;
  localparam logic [2:0] C_EOB     = 3'b111;

`ifdef PERIPHERAL_SPRAM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel;
  logic          we;
  logic [1:0]    bte;
  logic [2:0]    cti;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  peripheral_wb_spram_burst #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .AW      (AW),
    .MEMFILE ("")
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_bte_i (bte),
    .wb_cti_i (cti),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_dat_o (dat_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          err;
    logic          rd;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] model [DEPTH];

  // Monitor: every beat the master sees completed must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && cyc && stb && (ack || err)) begin
      checks++;
      if (ack && err) begin
        failures++;
        $display("FAIL ack_err_excl adr=%0d ack=%0b err=%0b required not both", adr, ack, err);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat adr=%0d ack=%0b err=%0b required no response", adr, ack, err);
      end else begin
        mon_e = exp_q.pop_front();
        if (err !== mon_e.err) begin
          failures++;
          $display("FAIL beat_resp adr=%0d err=%0b required err=%0b", mon_e.adr, err, mon_e.err);
        end else if (mon_e.err && dat_o !== '0) begin
          failures++;
          $display("FAIL err_data adr=%0d dat=%h required 0", mon_e.adr, dat_o);
        end else if (!mon_e.err && mon_e.rd && dat_o !== mon_e.dat) begin
          failures++;
          $display("FAIL rd_data adr=%0d dat=%h required %h", mon_e.adr, dat_o, mon_e.dat);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the beat.
  task automatic do_beat(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] c, input logic [1:0] b,
                         input int exp_wait);
    exp_t e;
    int   waits;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_i = d; sel = s; cti = c; bte = b;
    e.adr = a;
    e.rd  = !w;
    e.err = (int'(a) >= DEPTH);
    e.dat = '0;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < SW; k++) if (s[k]) model[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.dat = model[a];
      end
    end
    exp_q.push_back(e);
    waits = 0;
    @(negedge clk);
    while (!(ack || err) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    checks++;
    if (waits != exp_wait) begin
      failures++;
      $display("FAIL beat_wait adr=%0d waits=%0d required %0d", a, waits, exp_wait);
    end
    @(posedge clk); #1;
  endtask

  task automatic end_txn();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = C_CLASSIC;
    @(negedge clk);
    checks++;
    if (ack || err) begin
      failures++;
      $display("FAIL idle_after_txn ack=%0b err=%0b required 0/0", ack, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic [AW-1:0] start, input int n, input logic [1:0] b, input logic w,
                      input int gap_at, input int gap_len, input bit rsel);
    int            span;
    logic [AW-1:0] a;
    logic [2:0]    c;
    logic [SW-1:0] s;
    bit            gapped;
    span = (b == 2'd0) ? 0 : (2 << b);
    for (int i = 0; i < n; i++) begin
      gapped = (i == gap_at) && (gap_len > 0) && (i > 0);
      if (gapped) begin
        stb = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      if (span == 0) a = AW'(int'(start) + i);
      else           a = AW'((int'(start) / span) * span + (int'(start) + i) % span);
      c = (n == 1) ? C_CLASSIC : (i == n-1) ? C_EOB : C_INCR;
      s = rsel ? SW'($urandom) : {SW{1'b1}};
      do_beat(a, w, $urandom, s, c, b, (i == 0 || gapped || !BURST_EN) ? 1 : 0);
    end
    end_txn();
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_o !== '0) begin
      failures++;
      $display("FAIL %s ack=%0b err=%0b dat=%h required 0/0/0", tag, ack, err, dat_o);
    end
  endtask

  initial begin
    int            n;
    int            g;
    logic [AW-1:0] st;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; adr = '0; dat_i = '0; sel = '0;
    we = 1'b0; bte = 2'b00; cti = C_CLASSIC;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole array (last burst runs past DEPTH into error beats).
    for (int base = 0; base < 208; base += 16) xfer(AW'(base), 16, 2'b00, 1'b1, -1, 0, 1'b0);

    do_beat(8'd5, 1'b1, 32'hDEADBEEF, 4'b1111, C_CLASSIC, 2'b00, 1); end_txn();
    do_beat(8'd5, 1'b1, 32'h00001200, 4'b0010, C_CLASSIC, 2'b00, 1); end_txn();
    do_beat(8'd5, 1'b0, 32'h0,        4'b1111, C_CLASSIC, 2'b00, 1); end_txn();

    xfer(8'd10, 4, 2'b00, 1'b0, -1, 0, 1'b0);
    xfer(8'd6,  4, 2'b01, 1'b0, -1, 0, 1'b0);
    xfer(8'd13, 8, 2'b10, 1'b1, -1, 0, 1'b1);
    xfer(8'd8,  8, 2'b00, 1'b0, -1, 0, 1'b0);
    xfer(8'd20, 8, 2'b00, 1'b0,  3, 2, 1'b0);
    xfer(8'd27, 6, 2'b11, 1'b1,  2, 1, 1'b1);

    xfer(8'd199, 1, 2'b00, 1'b0, -1, 0, 1'b0);
    xfer(8'd200, 1, 2'b00, 1'b0, -1, 0, 1'b0);
    xfer(8'd250, 1, 2'b00, 1'b1, -1, 0, 1'b0);
    xfer(8'd198, 6, 2'b00, 1'b0, -1, 0, 1'b0);
    xfer(8'd254, 4, 2'b00, 1'b1, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      st = AW'($urandom_range(0, 255));
      n  = $urandom_range(1, 12);
      g  = (n > 2) ? $urandom_range(1, n-1) : -1;
      xfer(st, n, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset while a burst is in flight.
    do_beat(8'd40, 1'b0, 32'h0, 4'b1111, C_INCR, 2'b00, 1);
    adr = 8'd41;
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_burst");
    cyc = 1'b0; stb = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(8'd41, 1, 2'b00, 1'b0, -1, 0, 1'b0);

    for (int base = 0; base < 208; base += 16) xfer(AW'(base), 16, 2'b00, 1'b0, -1, 0, 1'b0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expect pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
